// File: rtl/load_store_unit.sv
// Memory stage: turns the registered ALU result into a data-memory transaction
// (req/gnt/rvalid), aligns and extends load data, and emits one-cycle writebacks.
module load_store_unit #(
  parameter int DWIDTH     = 32,
  parameter int MEM_AWIDTH = 30,
  parameter int RWIDTH     = 5
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  i_valid,
  output logic                  o_ready,
  input  logic [DWIDTH-1:0]     i_alu_result,
  input  logic [DWIDTH-1:0]     i_store_data,
  input  logic [2:0]            i_funct3,
  input  logic                  i_is_load,
  input  logic                  i_is_store,
  input  logic [RWIDTH-1:0]     i_rd,
  output logic                  o_mem_req,
  output logic                  o_mem_we,
  output logic [MEM_AWIDTH-1:0] o_mem_addr,
  output logic [3:0]            o_mem_be,
  output logic [DWIDTH-1:0]     o_mem_wdata,
  input  logic                  i_mem_gnt,
  input  logic                  i_mem_rvalid,
  input  logic [DWIDTH-1:0]     i_mem_rdata,
  output logic                  o_wb_valid,
  output logic [RWIDTH-1:0]     o_wb_rd,
  output logic [DWIDTH-1:0]     o_wb_data,
  output logic                  o_exc,
  output logic [DWIDTH-1:0]     o_exc_addr
);

  typedef enum logic [1:0] {IDLE = 2'd0, REQ = 2'd1, WAIT = 2'd2} state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [DWIDTH-1:0] r_addr;
  logic [2:0]        r_funct3;
  logic [RWIDTH-1:0] r_rd;
  logic              r_mem_we;
  logic [3:0]        r_mem_be;
  logic [DWIDTH-1:0] r_mem_wdata;
  logic              r_wb_valid;
  logic [RWIDTH-1:0] r_wb_rd;
  logic [DWIDTH-1:0] r_wb_data;
  logic              r_exc;
  logic [DWIDTH-1:0] r_exc_addr;

  logic w_accept;
  logic w_is_mem;
  logic w_bad_f3;
  logic w_misaligned;
  logic w_illegal;

  function automatic logic [3:0] f_be(input logic [2:0] f3, input logic [1:0] off);
    case (f3[1:0])
      2'd0:    f_be = 4'b0001 << off;
      2'd1:    f_be = 4'b0011 << off;
      default: f_be = 4'b1111;
    endcase
  endfunction

  function automatic logic [DWIDTH-1:0] f_wdata(input logic [2:0] f3, input logic [DWIDTH-1:0] d);
    case (f3[1:0])
      2'd0:    f_wdata = {4{d[7:0]}};
      2'd1:    f_wdata = {2{d[15:0]}};
      default: f_wdata = d;
    endcase
  endfunction

  // Shift the addressed lane down to bit 0, then extend by size/sign.
  function automatic logic [DWIDTH-1:0] f_load(input logic [2:0] f3, input logic [1:0] off,
                                               input logic [DWIDTH-1:0] w);
    logic [DWIDTH-1:0] sh;
    sh = w >> {off, 3'b000};
    case (f3)
      3'd0:    f_load = {{24{sh[7]}}, sh[7:0]};
      3'd1:    f_load = {{16{sh[15]}}, sh[15:0]};
      3'd4:    f_load = {24'd0, sh[7:0]};
      3'd5:    f_load = {16'd0, sh[15:0]};
      default: f_load = w;
    endcase
  endfunction

  assign o_ready      = (r_state == IDLE);
  assign w_accept     = i_valid && o_ready;
  assign w_is_mem     = i_is_load || i_is_store;
  assign w_bad_f3     = (i_is_load && (i_funct3 == 3'd3 || i_funct3[2:1] == 2'b11)) ||
                        (i_is_store && (i_funct3 > 3'd2));
  assign w_misaligned = (i_funct3[1:0] == 2'd1 && i_alu_result[0]) ||
                        (i_funct3[1:0] == 2'd2 && i_alu_result[1:0] != 2'b00);
  assign w_illegal    = (i_is_load && i_is_store) || w_bad_f3 || w_misaligned;

  assign o_mem_req   = (r_state == REQ);
  assign o_mem_we    = r_mem_we;
  assign o_mem_addr  = r_addr[DWIDTH-1:2];
  assign o_mem_be    = r_mem_be;
  assign o_mem_wdata = r_mem_wdata;
  assign o_wb_valid  = r_wb_valid;
  assign o_wb_rd     = r_wb_rd;
  assign o_wb_data   = r_wb_data;
  assign o_exc       = r_exc;
  assign o_exc_addr  = r_exc_addr;

  // Next-state logic.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE: begin
        if (w_accept && w_is_mem && !w_illegal) w_state_nxt = REQ;
        else                                    w_state_nxt = IDLE;
      end
      REQ: begin
        if (i_mem_gnt) w_state_nxt = r_mem_we ? IDLE : WAIT;
        else           w_state_nxt = REQ;
      end
      WAIT: begin
        if (i_mem_rvalid) w_state_nxt = IDLE;
        else              w_state_nxt = WAIT;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= IDLE;
    else          r_state <= w_state_nxt;
  end

  // Datapath: latch the op, drive memory outputs, produce wb/exc pulses.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_addr      <= '0;
      r_funct3    <= 3'd0;
      r_rd        <= '0;
      r_mem_we    <= 1'b0;
      r_mem_be    <= 4'd0;
      r_mem_wdata <= '0;
      r_wb_valid  <= 1'b0;
      r_wb_rd     <= '0;
      r_wb_data   <= '0;
      r_exc       <= 1'b0;
      r_exc_addr  <= '0;
    end else begin
      r_wb_valid <= 1'b0;
      r_exc      <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            if (!w_is_mem) begin
              r_wb_valid <= (i_rd != '0);
              r_wb_data  <= i_alu_result;
              r_wb_rd    <= i_rd;
            end else if (w_illegal) begin
              r_exc      <= 1'b1;
              r_exc_addr <= i_alu_result;
            end else begin
              r_addr      <= i_alu_result;
              r_funct3    <= i_funct3;
              r_rd        <= i_rd;
              r_mem_we    <= i_is_store;
              r_mem_be    <= f_be(i_funct3, i_alu_result[1:0]);
              r_mem_wdata <= f_wdata(i_funct3, i_store_data);
            end
          end
        end
        REQ: begin
          if (i_mem_gnt) begin
            r_mem_we <= 1'b0;
            r_mem_be <= 4'd0;
          end
        end
        WAIT: begin
          if (i_mem_rvalid) begin
            r_wb_valid <= (r_rd != '0);
            r_wb_data  <= f_load(r_funct3, r_addr[1:0], i_mem_rdata);
            r_wb_rd    <= r_rd;
          end
        end
        default: begin
          r_mem_we <= 1'b0;
          r_mem_be <= 4'd0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: directed cases plus randomized ops
// checked against an arithmetic reference model of the load/store rules.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        i_valid;
  logic        o_ready;
  logic [31:0] i_alu_result;
  logic [31:0] i_store_data;
  logic [2:0]  i_funct3;
  logic        i_is_load;
  logic        i_is_store;
  logic [4:0]  i_rd;
  logic        o_mem_req;
  logic        o_mem_we;
  logic [29:0] o_mem_addr;
  logic [3:0]  o_mem_be;
  logic [31:0] o_mem_wdata;
  logic        i_mem_gnt;
  logic        i_mem_rvalid;
  logic [31:0] i_mem_rdata;
  logic        o_wb_valid;
  logic [4:0]  o_wb_rd;
  logic [31:0] o_wb_data;
  logic        o_exc;
  logic [31:0] o_exc_addr;

  int n_pass  = 0;
  int n_total = 0;

  load_store_unit dut (
    .clk(clk), .reset_n(reset_n), .i_valid(i_valid), .o_ready(o_ready),
    .i_alu_result(i_alu_result), .i_store_data(i_store_data), .i_funct3(i_funct3),
    .i_is_load(i_is_load), .i_is_store(i_is_store), .i_rd(i_rd),
    .o_mem_req(o_mem_req), .o_mem_we(o_mem_we), .o_mem_addr(o_mem_addr),
    .o_mem_be(o_mem_be), .o_mem_wdata(o_mem_wdata), .i_mem_gnt(i_mem_gnt),
    .i_mem_rvalid(i_mem_rvalid), .i_mem_rdata(i_mem_rdata), .o_wb_valid(o_wb_valid),
    .o_wb_rd(o_wb_rd), .o_wb_data(o_wb_data), .o_exc(o_exc), .o_exc_addr(o_exc_addr)
  );

  always #5 clk = ~clk;

  // Reference model, written from the architectural rules.
  function automatic bit m_illegal(input bit l, input bit s, input int f3, input logic [31:0] a);
    bit half, word;
    half = (f3 % 4 == 1);
    word = (f3 % 4 == 2);
    if (l && s) return 1'b1;
    if (l && (f3 == 3 || f3 == 6 || f3 == 7)) return 1'b1;
    if (s && f3 > 2) return 1'b1;
    if (half && (a % 2 != 0)) return 1'b1;
    if (word && (a % 4 != 0)) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [3:0] m_be(input int f3, input logic [31:0] a);
    int off;
    off = a % 4;
    if (f3 % 4 == 0) return 4'(1 << off);
    if (f3 % 4 == 1) return 4'(3 << off);
    return 4'hF;
  endfunction

  function automatic logic [31:0] m_wdata(input int f3, input logic [31:0] d);
    if (f3 % 4 == 0) return (d % 256) * 32'h01010101;
    if (f3 % 4 == 1) return (d % 65536) * 32'h00010001;
    return d;
  endfunction

  function automatic logic [31:0] m_load(input int f3, input logic [31:0] a, input logic [31:0] w);
    logic [31:0] v;
    int off;
    off = a % 4;
    v = w / (32'd1 << (8 * off));
    case (f3)
      0: begin v = v % 256;   if (v >= 128)   v = v + 32'hFFFFFF00; end
      1: begin v = v % 65536; if (v >= 32768) v = v + 32'hFFFF0000; end
      4: v = v % 256;
      5: v = v % 65536;
      default: v = w;
    endcase
    return v;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    i_valid = 1'b0; i_alu_result = 32'd0; i_store_data = 32'd0; i_funct3 = 3'd0;
    i_is_load = 1'b0; i_is_store = 1'b0; i_rd = 5'd0;
    i_mem_gnt = 1'b0; i_mem_rvalid = 1'b0; i_mem_rdata = 32'd0;
  endtask

  // Issue one op and follow it through the memory handshake to completion.
  task automatic do_op(input bit l, input bit s, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] sd, input logic [4:0] rd, input logic [31:0] rdata,
                       input int gd, input int rvd);
    bit ill;
    ill = m_illegal(l, s, int'(f3), a);
    n_total++; if (o_ready !== 1'b1) $display("FAIL ready_pre: got %b want 1", o_ready); else n_pass++;
    i_valid = 1'b1; i_is_load = l; i_is_store = s; i_funct3 = f3;
    i_alu_result = a; i_store_data = sd; i_rd = rd;
    step();
    idle_inputs();
    if (!l && !s) begin
      n_total++; if (o_wb_valid !== (rd != 5'd0)) $display("FAIL nm_wb_valid: got %b want %b", o_wb_valid, rd != 5'd0); else n_pass++;
      n_total++; if (o_exc !== 1'b0) $display("FAIL nm_exc: got %b want 0", o_exc); else n_pass++;
      if (rd != 5'd0) begin
        n_total++; if (o_wb_data !== a) $display("FAIL nm_wb_data: got %h want %h", o_wb_data, a); else n_pass++;
        n_total++; if (o_wb_rd !== rd) $display("FAIL nm_wb_rd: got %0d want %0d", o_wb_rd, rd); else n_pass++;
      end
    end else if (ill) begin
      n_total++; if (o_exc !== 1'b1) $display("FAIL exc: got %b want 1 (a=%h f3=%0d l=%b s=%b)", o_exc, a, f3, l, s); else n_pass++;
      n_total++; if (o_exc_addr !== a) $display("FAIL exc_addr: got %h want %h", o_exc_addr, a); else n_pass++;
      n_total++; if (o_wb_valid !== 1'b0) $display("FAIL exc_wb_valid: got %b want 0", o_wb_valid); else n_pass++;
      n_total++; if (o_mem_req !== 1'b0) $display("FAIL exc_req: got %b want 0", o_mem_req); else n_pass++;
      n_total++; if (o_ready !== 1'b1) $display("FAIL exc_ready: got %b want 1", o_ready); else n_pass++;
    end else begin
      for (int k = 0; k <= gd; k++) begin
        n_total++; if (o_mem_req !== 1'b1) $display("FAIL req_held: got %b want 1 (cycle %0d)", o_mem_req, k); else n_pass++;
        n_total++; if (o_mem_addr !== a[31:2]) $display("FAIL mem_addr: got %h want %h", o_mem_addr, a[31:2]); else n_pass++;
        n_total++; if (o_mem_be !== m_be(int'(f3), a)) $display("FAIL mem_be: got %b want %b", o_mem_be, m_be(int'(f3), a)); else n_pass++;
        n_total++; if (o_mem_we !== s) $display("FAIL mem_we: got %b want %b", o_mem_we, s); else n_pass++;
        n_total++; if (o_wb_valid !== 1'b0) $display("FAIL req_wb_valid: got %b want 0", o_wb_valid); else n_pass++;
        if (s) begin
          n_total++; if (o_mem_wdata !== m_wdata(int'(f3), sd)) $display("FAIL mem_wdata: got %h want %h", o_mem_wdata, m_wdata(int'(f3), sd)); else n_pass++;
        end
        if (k == gd) i_mem_gnt = 1'b1;
        step();
        i_mem_gnt = 1'b0;
      end
      n_total++; if (o_mem_req !== 1'b0) $display("FAIL req_drop: got %b want 0", o_mem_req); else n_pass++;
      if (s) begin
        n_total++; if (o_ready !== 1'b1) $display("FAIL st_ready: got %b want 1", o_ready); else n_pass++;
        n_total++; if (o_wb_valid !== 1'b0) $display("FAIL st_wb_valid: got %b want 0", o_wb_valid); else n_pass++;
        n_total++; if (o_mem_we !== 1'b0) $display("FAIL st_we_drop: got %b want 0", o_mem_we); else n_pass++;
      end else begin
        n_total++; if (o_ready !== 1'b0) $display("FAIL wait_ready: got %b want 0", o_ready); else n_pass++;
        for (int j = 0; j < rvd; j++) begin
          n_total++; if (o_wb_valid !== 1'b0) $display("FAIL wait_wb_valid: got %b want 0", o_wb_valid); else n_pass++;
          step();
        end
        i_mem_rvalid = 1'b1; i_mem_rdata = rdata;
        step();
        i_mem_rvalid = 1'b0; i_mem_rdata = 32'd0;
        n_total++; if (o_wb_valid !== (rd != 5'd0)) $display("FAIL ld_wb_valid: got %b want %b", o_wb_valid, rd != 5'd0); else n_pass++;
        n_total++; if (o_ready !== 1'b1) $display("FAIL ld_ready: got %b want 1", o_ready); else n_pass++;
        n_total++; if (o_exc !== 1'b0) $display("FAIL ld_exc: got %b want 0", o_exc); else n_pass++;
        if (rd != 5'd0) begin
          n_total++; if (o_wb_data !== m_load(int'(f3), a, rdata)) $display("FAIL ld_wb_data: got %h want %h (f3=%0d a=%h)", o_wb_data, m_load(int'(f3), a, rdata), f3, a); else n_pass++;
          n_total++; if (o_wb_rd !== rd) $display("FAIL ld_wb_rd: got %0d want %0d", o_wb_rd, rd); else n_pass++;
        end
      end
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    idle_inputs();
    repeat (2) @(posedge clk);
    #1;
    n_total++; if (o_ready !== 1'b1) $display("FAIL rst_ready: got %b want 1", o_ready); else n_pass++;
    n_total++; if (o_mem_req !== 1'b0) $display("FAIL rst_req: got %b want 0", o_mem_req); else n_pass++;
    n_total++; if (o_mem_we !== 1'b0) $display("FAIL rst_we: got %b want 0", o_mem_we); else n_pass++;
    n_total++; if (o_mem_be !== 4'd0) $display("FAIL rst_be: got %b want 0", o_mem_be); else n_pass++;
    n_total++; if (o_wb_valid !== 1'b0) $display("FAIL rst_wb_valid: got %b want 0", o_wb_valid); else n_pass++;
    n_total++; if (o_exc !== 1'b0) $display("FAIL rst_exc: got %b want 0", o_exc); else n_pass++;
    n_total++; if (o_wb_data !== 32'd0) $display("FAIL rst_wb_data: got %h want 0", o_wb_data); else n_pass++;
    reset_n = 1'b1;
    step();
  endtask

  task automatic test_nonmem_stream();
    logic [31:0] vals [3];
    vals[0] = 32'h11; vals[1] = 32'h22; vals[2] = 32'h33;
    for (int i = 0; i < 3; i++) begin
      n_total++; if (o_ready !== 1'b1) $display("FAIL stream_ready: got %b want 1", o_ready); else n_pass++;
      i_valid = 1'b1; i_alu_result = vals[i]; i_rd = 5'(i + 1);
      step();
      n_total++; if (o_wb_valid !== 1'b1) $display("FAIL stream_wb_valid: got %b want 1 (op %0d)", o_wb_valid, i); else n_pass++;
      n_total++; if (o_wb_data !== vals[i]) $display("FAIL stream_wb_data: got %h want %h", o_wb_data, vals[i]); else n_pass++;
      n_total++; if (o_wb_rd !== 5'(i + 1)) $display("FAIL stream_wb_rd: got %0d want %0d", o_wb_rd, i + 1); else n_pass++;
    end
    idle_inputs();
    step();
    n_total++; if (o_wb_valid !== 1'b0) $display("FAIL stream_wb_end: got %b want 0", o_wb_valid); else n_pass++;
  endtask

  task automatic test_store_byte();
    do_op(1'b0, 1'b1, 3'd0, 32'h0000_1003, 32'h0000_00A5, 5'd7, 32'd0, 2, 0);
    n_total++; if (o_wb_valid !== 1'b0) $display("FAIL sb_no_wb: got %b want 0", o_wb_valid); else n_pass++;
  endtask

  task automatic test_load_half();
    do_op(1'b1, 1'b0, 3'd1, 32'h0000_2002, 32'd0, 5'd9, 32'h8001_1234, 0, 0);
    n_total++; if (o_wb_data !== 32'hFFFF_8001) $display("FAIL lh_data: got %h want ffff8001", o_wb_data); else n_pass++;
    do_op(1'b1, 1'b0, 3'd5, 32'h0000_2002, 32'd0, 5'd9, 32'h8001_1234, 1, 1);
    n_total++; if (o_wb_data !== 32'h0000_8001) $display("FAIL lhu_data: got %h want 00008001", o_wb_data); else n_pass++;
  endtask

  task automatic test_exceptions();
    do_op(1'b1, 1'b0, 3'd2, 32'h0000_3006, 32'd0, 5'd3, 32'd0, 0, 0);
    step();
    n_total++; if (o_exc !== 1'b0) $display("FAIL exc_pulse: got %b want 0", o_exc); else n_pass++;
    do_op(1'b1, 1'b0, 3'd3, 32'h0000_3000, 32'd0, 5'd3, 32'd0, 0, 0);
    do_op(1'b0, 1'b1, 3'd4, 32'h0000_3000, 32'd0, 5'd3, 32'd0, 0, 0);
    do_op(1'b1, 1'b1, 3'd0, 32'h0000_3001, 32'd0, 5'd0, 32'd0, 0, 0);
    do_op(1'b0, 1'b1, 3'd1, 32'h0000_3001, 32'd0, 5'd3, 32'd0, 0, 0);
  endtask

  task automatic test_rd_zero();
    do_op(1'b1, 1'b0, 3'd2, 32'h0000_4000, 32'd0, 5'd0, 32'hDEAD_BEEF, 1, 2);
  endtask

  task automatic test_back_to_back();
    do_op(1'b0, 1'b1, 3'd2, 32'h0000_5000, 32'h1234_5678, 5'd1, 32'd0, 0, 0);
    do_op(1'b1, 1'b0, 3'd0, 32'h0000_5001, 32'd0, 5'd2, 32'h0000_8000, 0, 0);
    do_op(1'b0, 1'b0, 3'd0, 32'hCAFE_0001, 32'd0, 5'd4, 32'd0, 0, 0);
    do_op(1'b1, 1'b0, 3'd4, 32'h0000_5003, 32'd0, 5'd5, 32'h8100_0000, 0, 0);
  endtask

  task automatic test_random();
    bit l, s;
    int kind;
    logic [2:0]  f3;
    logic [31:0] a;
    for (int n = 0; n < 60; n++) begin
      kind = $urandom_range(0, 3);
      l = (kind == 1) || (kind == 3 && $urandom_range(0, 1) == 1);
      s = (kind == 2) || (kind == 3 && $urandom_range(0, 1) == 1);
      f3 = 3'($urandom_range(0, 7));
      a = $urandom;
      if ($urandom_range(0, 2) != 0) a = a & 32'hFFFF_FFFC | 32'(f3 == 3'd0 || f3 == 3'd4 ? $urandom_range(0, 3) : 0);
      do_op(l, s, f3, a, $urandom, 5'($urandom_range(0, 31)), $urandom,
            $urandom_range(0, 3), $urandom_range(0, 2));
    end
  endtask

  task automatic test_reset_in_wait();
    i_valid = 1'b1; i_is_load = 1'b1; i_funct3 = 3'd2; i_alu_result = 32'h0000_0100; i_rd = 5'd5;
    step();
    idle_inputs();
    i_mem_gnt = 1'b1;
    step();
    i_mem_gnt = 1'b0;
    n_total++; if (o_ready !== 1'b0) $display("FAIL riw_in_wait: got %b want 0", o_ready); else n_pass++;
    reset_n = 1'b0;
    #1;
    n_total++; if (o_mem_req !== 1'b0) $display("FAIL riw_req: got %b want 0", o_mem_req); else n_pass++;
    n_total++; if (o_wb_valid !== 1'b0) $display("FAIL riw_wb: got %b want 0", o_wb_valid); else n_pass++;
    n_total++; if (o_ready !== 1'b1) $display("FAIL riw_ready: got %b want 1", o_ready); else n_pass++;
    step();
    reset_n = 1'b1;
    i_mem_rvalid = 1'b1; i_mem_rdata = 32'h5555_AAAA;
    step();
    idle_inputs();
    n_total++; if (o_wb_valid !== 1'b0) $display("FAIL riw_stray_wb: got %b want 0", o_wb_valid); else n_pass++;
    step();
    n_total++; if (o_wb_valid !== 1'b0) $display("FAIL riw_stray_wb2: got %b want 0", o_wb_valid); else n_pass++;
    n_total++; if (o_ready !== 1'b1) $display("FAIL riw_ready_after: got %b want 1", o_ready); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_nonmem_stream();
    test_store_byte();
    test_load_half();
    test_exceptions();
    test_rd_zero();
    test_back_to_back();
    test_random();
    test_reset_in_wait();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
